stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_sequencer_if.sv | 38 +++
 rtl/stack_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
//==============================================================================
// stack_sequencer_if : instruction/memory handshake bundle for stack_sequencer
// Rev 1.0
//==============================================================================
`default_nettype none

interface stack_sequencer_if;
  logic [15:0] inst;
  logic        inst_valid;
  logic        mem_ack;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  addr_sel;
  logic [15:0] vec_addr;
  logic [1:0]  wdata_sel;
  logic        sp_dec;
  logic        sp_inc;
  logic        pc_ld_hi;
  logic        pc_ld_lo;
  logic        pc_ld_reg;
  logic        flags_ld;
  logic        done;

  modport master (
    output inst, inst_valid, mem_ack,
    input  busy, mem_req, mem_we, addr_sel, vec_addr, wdata_sel,
           sp_dec, sp_inc, pc_ld_hi, pc_ld_lo, pc_ld_reg, flags_ld, done
  );

  modport slave (
    input  inst, inst_valid, mem_ack,
    output busy, mem_req, mem_we, addr_sel, vec_addr, wdata_sel,
           sp_dec, sp_inc, pc_ld_hi, pc_ld_lo, pc_ld_reg, flags_ld, done
  );
endinterface

`default_nettype wire

// File: rtl/stack_sequencer.sv
//==============================================================================
// stack_sequencer : CALL/INT/RET/RTI/RESET stack and vector micro-sequencer
// Rev 1.0
//==============================================================================
`default_nettype none

module stack_sequencer #(
  parameter logic [15:0] RESET_VEC    = 16'h0000,
  parameter logic [15:0] INT_VEC_BASE = 16'h0002
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  stack_sequencer_if.slave bus_if
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PUSH_FL = 4'd1,
    S_PUSH_HI = 4'd2,
    S_PUSH_LO = 4'd3,
    S_POP_LO  = 4'd4,
    S_POP_HI  = 4'd5,
    S_POP_FL  = 4'd6,
    S_VEC_HI  = 4'd7,
    S_VEC_LO  = 4'd8,
    S_LD_REG  = 4'd9
  } state_t;

  localparam logic [4:0] c_OP_INT   = 5'b01000;
  localparam logic [4:0] c_OP_CALL  = 5'b01001;
  localparam logic [4:0] c_OP_RET   = 5'b11100;
  localparam logic [4:0] c_OP_RTI   = 5'b11101;
  localparam logic [4:0] c_OP_RESET = 5'b11110;

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] vec_q, vec_d;

  logic [4:0]  w_opcode;
  logic        w_handled;
  logic        w_accept;
  logic        w_ack;
  logic        w_unused;

  logic        w_busy, w_mem_req, w_mem_we;
  logic [1:0]  w_addr_sel, w_wdata_sel;
  logic        w_sp_dec, w_sp_inc, w_ld_hi, w_ld_lo, w_ld_reg, w_flags_ld, w_done;

  assign w_opcode  = bus_if.inst[15:11];
  assign w_handled = (w_opcode == c_OP_INT)  || (w_opcode == c_OP_CALL) ||
                     (w_opcode == c_OP_RET)  || (w_opcode == c_OP_RTI)  ||
                     (w_opcode == c_OP_RESET);
  assign w_accept  = rst_n && (state_q == S_IDLE) && bus_if.inst_valid && w_handled;
  assign w_unused  = &{1'b0, bus_if.inst[10:2]};

  // Memory states advance only on an acknowledged request; ack without a request is dropped.
  assign w_ack = w_mem_req && bus_if.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_VEC_HI;
      op_q    <= c_OP_RESET;
      vec_q   <= RESET_VEC;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    vec_d       = vec_q;
    w_busy      = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_addr_sel  = 2'd0;
    w_wdata_sel = 2'd0;
    w_sp_dec    = 1'b0;
    w_sp_inc    = 1'b0;
    w_ld_hi     = 1'b0;
    w_ld_lo     = 1'b0;
    w_ld_reg    = 1'b0;
    w_flags_ld  = 1'b0;
    w_done      = 1'b0;

    // Outputs stay quiet while reset is held, even though the state already sits in VEC_HI.
    if (rst_n) begin
      w_busy = (state_q != S_IDLE) || w_accept;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            op_d = w_opcode;
            case (w_opcode)
              c_OP_INT: begin
                state_d = S_PUSH_FL;
                vec_d   = INT_VEC_BASE + {13'd0, bus_if.inst[1:0], 1'b0};
              end
              c_OP_CALL:  state_d = S_PUSH_HI;
              c_OP_RESET: begin
                state_d = S_VEC_HI;
                vec_d   = RESET_VEC;
              end
              default:    state_d = S_POP_LO;
            endcase
          end
        end
        S_PUSH_FL, S_PUSH_HI, S_PUSH_LO: begin
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b1;
          w_wdata_sel = (state_q == S_PUSH_FL) ? 2'd2 :
                        (state_q == S_PUSH_HI) ? 2'd0 : 2'd1;
          if (bus_if.mem_ack) begin
            w_sp_dec = 1'b1;
            case (state_q)
              S_PUSH_FL: state_d = S_PUSH_HI;
              S_PUSH_HI: state_d = S_PUSH_LO;
              default:   state_d = (op_q == c_OP_CALL) ? S_LD_REG : S_VEC_HI;
            endcase
          end
        end
        S_POP_LO, S_POP_HI, S_POP_FL: begin
          w_mem_req  = 1'b1;
          w_addr_sel = 2'd1;
          if (bus_if.mem_ack) begin
            w_sp_inc = 1'b1;
            case (state_q)
              S_POP_LO: begin
                w_ld_lo = 1'b1;
                state_d = S_POP_HI;
              end
              S_POP_HI: begin
                w_ld_hi = 1'b1;
                if (op_q == c_OP_RTI) begin
                  state_d = S_POP_FL;
                end else begin
                  w_done  = 1'b1;
                  state_d = S_IDLE;
                end
              end
              default: begin
                w_flags_ld = 1'b1;
                w_done     = 1'b1;
                state_d    = S_IDLE;
              end
            endcase
          end
        end
        S_VEC_HI: begin
          w_mem_req  = 1'b1;
          w_addr_sel = 2'd2;
          if (bus_if.mem_ack) begin
            w_ld_hi = 1'b1;
            vec_d   = vec_q + 16'd1;
            state_d = S_VEC_LO;
          end
        end
        S_VEC_LO: begin
          w_mem_req  = 1'b1;
          w_addr_sel = 2'd2;
          if (bus_if.mem_ack) begin
            w_ld_lo = 1'b1;
            w_done  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_LD_REG: begin
          w_ld_reg = 1'b1;
          w_done   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus_if.busy      = w_busy;
  assign bus_if.mem_req   = w_mem_req;
  assign bus_if.mem_we    = w_mem_we;
  assign bus_if.addr_sel  = w_addr_sel;
  assign bus_if.vec_addr  = vec_q;
  assign bus_if.wdata_sel = w_wdata_sel;
  assign bus_if.sp_dec    = w_sp_dec   && w_ack;
  assign bus_if.sp_inc    = w_sp_inc   && w_ack;
  assign bus_if.pc_ld_hi  = w_ld_hi    && w_ack;
  assign bus_if.pc_ld_lo  = w_ld_lo    && w_ack;
  assign bus_if.flags_ld  = w_flags_ld && w_ack;
  assign bus_if.pc_ld_reg = w_ld_reg;
  assign bus_if.done      = w_done;

endmodule

`default_nettype wire

// File: tb/tb_stack_sequencer.sv
//==============================================================================
// tb_stack_sequencer : scoreboard bench for stack_sequencer
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_stack_sequencer;

  localparam logic [15:0] c_RESET_VEC = 16'h0000;
  localparam logic [15:0] c_INT_BASE  = 16'h0002;

  localparam logic [6:0] c_DEC  = 7'b1000000;
  localparam logic [6:0] c_INC  = 7'b0100000;
  localparam logic [6:0] c_HI   = 7'b0010000;
  localparam logic [6:0] c_LO   = 7'b0001000;
  localparam logic [6:0] c_REG  = 7'b0000100;
  localparam logic [6:0] c_FL   = 7'b0000010;
  localparam logic [6:0] c_DONE = 7'b0000001;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  asel;
    logic [15:0] vaddr;
    logic [1:0]  wsel;
    logic [6:0]  st;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stack_sequencer_if u_if ();

  stack_sequencer #(
    .RESET_VEC    (c_RESET_VEC),
    .INT_VEC_BASE (c_INT_BASE)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (u_if.slave)
  );

  int   checks    = 0;
  int   errors    = 0;
  int   ack_delay = 0;
  bit   ack_force = 1'b0;
  int   wait_cnt  = 0;
  int   busy_cnt  = 0;
  ev_t  q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ev_t mk(input bit req, input bit we, input bit [1:0] asel,
                             input bit [15:0] va, input bit [1:0] ws, input bit [6:0] st);
    ev_t e;
    e.req   = req;
    e.we    = we;
    e.asel  = asel;
    e.vaddr = va;
    e.wsel  = ws;
    e.st    = st;
    return e;
  endfunction

  // vec_addr only matters on vector reads, wdata_sel only on writes
  function automatic ev_t snap();
    ev_t e;
    e.req   = u_if.mem_req;
    e.we    = u_if.mem_we;
    e.asel  = u_if.addr_sel;
    e.vaddr = (u_if.mem_req && u_if.addr_sel == 2'd2) ? u_if.vec_addr : 16'h0000;
    e.wsel  = (u_if.mem_req && u_if.mem_we) ? u_if.wdata_sel : 2'd0;
    e.st    = {u_if.sp_dec, u_if.sp_inc, u_if.pc_ld_hi, u_if.pc_ld_lo,
               u_if.pc_ld_reg, u_if.flags_ld, u_if.done};
    return e;
  endfunction

  task automatic push_reset();
    q.push_back(mk(1, 0, 2, c_RESET_VEC,         0, c_HI));
    q.push_back(mk(1, 0, 2, c_RESET_VEC + 16'd1, 0, c_LO | c_DONE));
  endtask

  task automatic push_call();
    q.push_back(mk(1, 1, 0, 0, 0, c_DEC));
    q.push_back(mk(1, 1, 0, 0, 1, c_DEC));
    q.push_back(mk(0, 0, 0, 0, 0, c_REG | c_DONE));
  endtask

  task automatic push_int(input int k);
    logic [15:0] va;
    va = c_INT_BASE + 16'(2 * k);
    q.push_back(mk(1, 1, 0, 0,          2, c_DEC));
    q.push_back(mk(1, 1, 0, 0,          0, c_DEC));
    q.push_back(mk(1, 1, 0, 0,          1, c_DEC));
    q.push_back(mk(1, 0, 2, va,         0, c_HI));
    q.push_back(mk(1, 0, 2, va + 16'd1, 0, c_LO | c_DONE));
  endtask

  task automatic push_pop(input bit rti);
    q.push_back(mk(1, 0, 1, 0, 0, c_INC | c_LO));
    q.push_back(mk(1, 0, 1, 0, 0, rti ? (c_INC | c_HI) : (c_INC | c_HI | c_DONE)));
    if (rti) q.push_back(mk(1, 0, 1, 0, 0, c_INC | c_FL | c_DONE));
  endtask

  // Memory model and monitor: ack is decided at the falling edge, outputs sampled 1ns later.
  always @(negedge clk) begin
    ev_t s;
    ev_t e;
    if (!rst_n) begin
      wait_cnt     = 0;
      u_if.mem_ack = 1'b0;
    end else if (u_if.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        u_if.mem_ack = 1'b1;
        wait_cnt     = 0;
      end else begin
        u_if.mem_ack = ack_force;
        wait_cnt++;
      end
    end else begin
      u_if.mem_ack = ack_force;
      wait_cnt     = 0;
    end
    #1;
    s = snap();
    if (u_if.busy) busy_cnt++;
    if (!rst_n) begin
      check("rst_quiet", {23'd0, u_if.busy, u_if.mem_req, s.st}, 32'd0);
    end else if (s.req) begin
      if (q.size() == 0) begin
        check("unexp_req", {3'd0, s}, 32'd0);
      end else if (u_if.mem_ack) begin
        e = q.pop_front();
        check("access", {3'd0, s}, {3'd0, e});
      end else begin
        e = q[0];
        e.st = 7'd0;
        check("wait_ctl", {3'd0, s}, {3'd0, e});
      end
    end else if (s.st != 7'd0) begin
      if (q.size() != 0 && !q[0].req) begin
        e = q.pop_front();
        check("ld_reg", {3'd0, s}, {3'd0, e});
      end else begin
        check("stray", {25'd0, s.st}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [15:0] instr, input logic exp_busy);
    @(negedge clk);
    busy_cnt        = 0;
    u_if.inst       = instr;
    u_if.inst_valid = 1'b1;
    #2;
    check("accept_busy", {31'd0, u_if.busy}, {31'd0, exp_busy});
    @(negedge clk);
    u_if.inst_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) break;
      n++;
      if (n > max_cycles) begin
        check("timeout", 32'd1, 32'd0);
        q.delete();
        break;
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.inst       = 16'h0000;
    u_if.inst_valid = 1'b0;

    // Reset release with zero-wait memory: vector read 0 then 1, done on cycle 2
    push_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain(20);
    @(negedge clk);
    #2 check("reset_idle_busy", {31'd0, u_if.busy}, 32'd0);

    // CALL, zero-wait: busy for 4 cycles including accept
    push_call();
    issue(16'h4800, 1'b1);
    wait_drain(20);
    @(negedge clk);
    #2 check("call_idle_busy", {31'd0, u_if.busy}, 32'd0);
    check("call_busy_cycles", busy_cnt, 32'd4);

    // INT k=2 with 3 wait states per access; a CALL with k=3 arrives mid-sequence
    ack_delay = 3;
    push_int(2);
    issue(16'h4002, 1'b1);
    repeat (2) @(negedge clk);
    issue(16'h4803, 1'b1);
    wait_drain(200);
    check("int_vec_hold", {16'd0, u_if.vec_addr}, {16'd0, c_INT_BASE + 16'd5});

    // Unhandled opcode and spurious ack in idle
    ack_delay = 0;
    issue(16'h0000, 1'b0);
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    #2 check("idle_nobusy", {31'd0, u_if.busy}, 32'd0);

    // RTI with one wait state, RET zero-wait
    ack_delay = 1;
    push_pop(1'b1);
    issue(16'hE800, 1'b1);
    wait_drain(50);
    ack_delay = 0;
    push_pop(1'b0);
    issue(16'hE000, 1'b1);
    wait_drain(20);

    // RESET instruction with two wait states
    ack_delay = 2;
    push_reset();
    issue(16'hF000, 1'b1);
    wait_drain(50);
    @(negedge clk);
    #2 check("reset_vec_hold", {16'd0, u_if.vec_addr}, {16'd0, c_RESET_VEC + 16'd1});

    // Reset asserted during INT PUSH_HI: abort, then only the reset-vector sequence
    ack_delay = 3;
    push_int(1);
    issue(16'h4001, 1'b1);
    begin
      int n;
      n = 0;
      while (q.size() > 4 && n < 50) begin
        @(negedge clk);
        #2;
        n++;
      end
      check("reach_push_hi", q.size(), 32'd4);
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    push_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain(50);
    repeat (3) @(negedge clk);
    #2 check("final_idle", {31'd0, u_if.busy}, 32'd0);
    check("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
